cell_drop_controller: RTL
=========================

// Module: cell_drop_controller
// PURPOSE
//  Game sequencer for the falling-cell playfield: owns the ROWSxCOLS occupancy grid and runs
//  spawn -> gravity/move -> lock -> full-row scan -> row shift. Exposes a registered row-read
//  port so the VGA renderer can fetch any grid row, with the active cell merged into the data.
//  Sits between the input/tick logic and the VGA pixel path.
// PARAMETERS
//  ROWS     16  playfield rows, row 0 = top
//  COLS     16  playfield columns, col 0 = left
//  SPAWN_X  0   spawn column, must be < COLS
//  LINES_W  8   width of the cleared-lines counter
// PORTS
//  clk          in   1          system clock; the block's only clock
//  reset        in   1          asynchronous, active-low reset
//  start        in   1          1-cycle strobe: clear grid and begin a game (honoured in IDLE/GAMEOVER only)
//  tick         in   1          1-cycle gravity strobe
//  move_left    in   1          level, sampled on tick
//  move_right   in   1          level, sampled on tick
//  drop         in   1          1-cycle hard-drop strobe (HARD_DROP_EN only; ignored otherwise)
//  rd_row       in   Y_W        render row address, Y_W = $clog2(ROWS)
//  rd_data      out  COLS       grid[rd_row] | active-cell mask, registered, 1-cycle latency
//  active_x     out  X_W        active cell column, X_W = $clog2(COLS)
//  active_y     out  Y_W        active cell row
//  lock_pulse   out  1          high 1 cycle when the active cell is written into the grid
//  lines        out  LINES_W    rows cleared since start, saturating at all-ones
//  game_over    out  1          high while in GAMEOVER
// BEHAVIOUR
//  Reset: state IDLE, grid all 0, rd_data=0, active_x=SPAWN_X, active_y=0, lock_pulse=0,
//   lines=0, game_over=0. Reset mid-operation aborts any state immediately; no partial shift kept.
//  FSM: IDLE -start-> CLEAR; CLEAR zeroes one row per cycle (row 0..ROWS-1), lines<=0, -> SPAWN.
//   SPAWN (1 cycle): x<=SPAWN_X, y<=0; grid[0][SPAWN_X]==1 -> GAMEOVER, else -> FALL.
//   FALL: waits for tick. On tick, horizontal first: left&~right & x>0 & ~grid[y][x-1] -> x-1;
//    right&~left & x<COLS-1 & ~grid[y][x+1] -> x+1; both/neither/blocked -> no move.
//    Then gravity on the post-move column nx: y==ROWS-1 or grid[y+1][nx] -> LOCK, else y<=y+1.
//   LOCK (1 cycle): grid[y][x]<=1, lock_pulse=1, scan_row<=ROWS-1, -> SCAN.
//   SCAN (1 row/cycle): grid[scan_row] all 1s -> lines+=1 (sat), shift_row<=scan_row, -> SHIFT;
//    else scan_row==0 -> SPAWN, else scan_row-=1.
//   SHIFT (1 row/cycle): grid[shift_row]<=grid[shift_row-1]; at shift_row==0 write all 0s and
//    return to SCAN at the same scan_row (rows shifted in are re-checked).
//   GAMEOVER: game_over=1, grid frozen; start -> CLEAR.
//  tick/move/drop outside FALL are ignored, not queued. start outside IDLE/GAMEOVER ignored.
//  rd_data: next cycle = grid[rd_row] | ((state==FALL && rd_row==y) ? 1<<x : 0); rd_row>=ROWS -> 0.
//   Read port never stalls the FSM; it sees grid state as of the sampling edge.
// CONFIGURATION
//  HARD_DROP_EN defined: in FALL, drop (takes priority over a same-cycle tick) enters DROP state;
//   DROP moves y+1 per cycle, no horizontal move, ticks ignored, until blocked -> LOCK.
//  Undefined: no DROP state, drop input unused, behaviour otherwise identical.
// STRUCTURE
//  tetris_pkg: state enum (IDLE,CLEAR,SPAWN,FALL,DROP,LOCK,SCAN,SHIFT,GAMEOVER), default
//   ROWS/COLS constants, row-vector typedef.
//  Sub-module grid_row_store: ROWS row registers, single row write (data or zero), registered
//   read mux, combinational full-row flag for an addressed row, occupancy bit lookup.
// TESTING
//  1 Reset low mid-SHIFT -> next cycle state IDLE, all rd_data=0, lines=0, lock_pulse=0.
//  2 start, 16 ticks no moves -> cell lands y=15 x=0; lock_pulse 1 cycle; rd_data(15)=16'h0001.
//  3 Preload row 15 = 16'hFFFE by 15 drops at x=1..15; 16th cell locks at x=0 -> lines=1,
//    row 15 becomes prior row 14 (0), row 0 = 0.
//  4 move_left at x=0 and move_right at x=15 on tick -> x unchanged, y+1; both high -> no move.
//  5 Column SPAWN_X filled to row 0 -> SPAWN goes to GAMEOVER, game_over=1; start -> grid cleared.
//  6 HARD_DROP_EN: drop at y=0 on empty grid -> lock_pulse exactly 16 cycles later at y=15.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared types for the falling-cell playfield: sequencer state encoding,
// default playfield geometry and the row-vector type.
package tetris_pkg;

  localparam int ROWS_DEF = 16;
  localparam int COLS_DEF = 16;

  typedef logic [COLS_DEF-1:0] row_t;

  typedef enum logic [3:0] {
    IDLE,
    CLEAR,
    SPAWN,
    FALL,
    DROP,
    LOCK,
    SCAN,
    SHIFT,
    GAMEOVER
  } state_t;

endpackage

// File: rtl/grid_row_store.sv
// Occupancy grid storage: one register per row, a single row write port
// (data or zero), a combinational row read with full-row flag, a single-bit
// occupancy lookup and a registered render read port with a merge mask.
// Storage is padded to a power-of-two row count; the pad rows never get
// written, so out-of-range reads naturally return zero.
module grid_row_store #(
  parameter int ROWS = 16,
  parameter int COLS = 16,
  localparam int Y_W = $clog2(ROWS),
  localparam int X_W = $clog2(COLS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic            wr_zero,
  input  logic [Y_W-1:0]  wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic [Y_W-1:0]  row_a_addr,
  output logic [COLS-1:0] row_a,
  output logic            full_a,
  input  logic [Y_W-1:0]  bit_row,
  input  logic [X_W-1:0]  bit_col,
  output logic            bit_q,
  input  logic [Y_W-1:0]  rd_row,
  input  logic [COLS-1:0] rd_mask,
  output logic [COLS-1:0] rd_data
);

  localparam int NR = 1 << Y_W;

  logic [COLS-1:0] grid [NR];
  logic [COLS-1:0] bit_row_v;
  logic [COLS-1:0] rd_data_p1;

  // Row registers: cleared by reset, one row written per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NR; r++) grid[r] <= '0;
    end else if (wr_en) begin
      grid[wr_row] <= wr_zero ? '0 : wr_data;
    end
  end

  // Combinational lookups used by the sequencer.
  always_comb begin
    row_a     = grid[row_a_addr];
    full_a    = &row_a;
    bit_row_v = grid[bit_row];
    bit_q     = bit_row_v[bit_col];
  end

  // ---- render read stage: p0 address/mask -> p1 registered row ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data_p1 <= '0;
    else        rd_data_p1 <= grid[rd_row] | rd_mask;
  end

  assign rd_data = rd_data_p1;

endmodule

// File: rtl/cell_drop_controller.sv
// Falling-cell game sequencer: spawn -> gravity/move -> lock -> full-row scan
// -> row shift, with a registered render read port that merges the active
// cell. Optional hard drop is compiled in with the HARD_DROP_EN macro.
module cell_drop_controller
  import tetris_pkg::*;
#(
  parameter int ROWS    = ROWS_DEF,
  parameter int COLS    = COLS_DEF,
  parameter int SPAWN_X = 0,
  parameter int LINES_W = 8,
  localparam int Y_W = $clog2(ROWS),
  localparam int X_W = $clog2(COLS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               tick,
  input  logic               move_left,
  input  logic               move_right,
  input  logic               drop,
  input  logic [Y_W-1:0]     rd_row,
  output logic [COLS-1:0]    rd_data,
  output logic [X_W-1:0]     active_x,
  output logic [Y_W-1:0]     active_y,
  output logic               lock_pulse,
  output logic [LINES_W-1:0] lines,
  output logic               game_over
);

  function automatic logic [LINES_W-1:0] sat_inc(input logic [LINES_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [COLS-1:0] cell_mask(input logic [X_W-1:0] c);
    logic [COLS-1:0] m;
    m    = '0;
    m[c] = 1'b1;
    return m;
  endfunction

  state_t             state, state_d;
  logic [X_W-1:0]     x_q, x_d, nx;
  logic [Y_W-1:0]     y_q, y_d;
  logic [Y_W-1:0]     scan_q, scan_d;
  logic [Y_W-1:0]     shift_q, shift_d;
  logic [Y_W-1:0]     clr_q, clr_d;
  logic [LINES_W-1:0] lines_q, lines_d;
  logic               at_floor;

  logic               wr_en, wr_zero;
  logic [Y_W-1:0]     wr_row;
  logic [COLS-1:0]    wr_data;
  logic [Y_W-1:0]     row_a_addr;
  logic [COLS-1:0]    row_a;
  logic               full_a;
  logic [Y_W-1:0]     bit_row;
  logic [X_W-1:0]     bit_col;
  logic               bit_q;
  logic [COLS-1:0]    rd_mask;

`ifndef HARD_DROP_EN
  logic unused_drop;
  assign unused_drop = drop;
`endif

  grid_row_store #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_grid (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_zero    (wr_zero),
    .wr_row     (wr_row),
    .wr_data    (wr_data),
    .row_a_addr (row_a_addr),
    .row_a      (row_a),
    .full_a     (full_a),
    .bit_row    (bit_row),
    .bit_col    (bit_col),
    .bit_q      (bit_q),
    .rd_row     (rd_row),
    .rd_mask    (rd_mask),
    .rd_data    (rd_data)
  );

  assign at_floor = (y_q == Y_W'(ROWS - 1));

  // Active cell is only shown to the renderer while it is falling under ticks.
  always_comb begin
    rd_mask = '0;
    if (state == FALL && rd_row == y_q) rd_mask = cell_mask(x_q);
  end

  // Sequencer registers; reset aborts any scan/shift in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      x_q        <= X_W'(SPAWN_X);
      y_q        <= '0;
      scan_q     <= '0;
      shift_q    <= '0;
      clr_q      <= '0;
      lines_q    <= '0;
      lock_pulse <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state      <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      scan_q     <= scan_d;
      shift_q    <= shift_d;
      clr_q      <= clr_d;
      lines_q    <= lines_d;
      lock_pulse <= (state_d == LOCK);
      game_over  <= (state_d == GAMEOVER);
    end
  end

  // Next-state, cell motion and grid write control.
  always_comb begin
    state_d    = state;
    x_d        = x_q;
    y_d        = y_q;
    scan_d     = scan_q;
    shift_d    = shift_q;
    clr_d      = clr_q;
    lines_d    = lines_q;
    nx         = x_q;
    wr_en      = 1'b0;
    wr_zero    = 1'b0;
    wr_row     = y_q;
    wr_data    = '0;
    row_a_addr = y_q;
    bit_row    = y_q + 1'b1;
    bit_col    = x_q;

    unique case (state)
      IDLE, GAMEOVER: begin
        if (start) begin
          state_d = CLEAR;
          clr_d   = '0;
        end
      end

      CLEAR: begin
        wr_en   = 1'b1;
        wr_zero = 1'b1;
        wr_row  = clr_q;
        lines_d = '0;
        if (clr_q == Y_W'(ROWS - 1)) state_d = SPAWN;
        else                         clr_d   = clr_q + 1'b1;
      end

      SPAWN: begin
        x_d     = X_W'(SPAWN_X);
        y_d     = '0;
        bit_row = '0;
        bit_col = X_W'(SPAWN_X);
        state_d = bit_q ? GAMEOVER : FALL;
      end

      FALL: begin
`ifdef HARD_DROP_EN
        // The drop edge itself takes the first step down.
        if (drop) begin
          if (at_floor || bit_q) state_d = LOCK;
          else begin
            y_d     = y_q + 1'b1;
            state_d = DROP;
          end
        end else
`endif
        if (tick) begin
          if (move_left && !move_right && x_q != '0 && !row_a[x_q - 1'b1])
            nx = x_q - 1'b1;
          else if (move_right && !move_left && x_q != X_W'(COLS - 1) && !row_a[x_q + 1'b1])
            nx = x_q + 1'b1;
          x_d     = nx;
          bit_col = nx;
          if (at_floor || bit_q) state_d = LOCK;
          else                   y_d     = y_q + 1'b1;
        end
      end

`ifdef HARD_DROP_EN
      DROP: begin
        if (at_floor || bit_q) state_d = LOCK;
        else                   y_d     = y_q + 1'b1;
      end
`endif

      LOCK: begin
        wr_en   = 1'b1;
        wr_row  = y_q;
        wr_data = row_a | cell_mask(x_q);
        scan_d  = Y_W'(ROWS - 1);
        state_d = SCAN;
      end

      SCAN: begin
        row_a_addr = scan_q;
        if (full_a) begin
          lines_d = sat_inc(lines_q);
          shift_d = scan_q;
          state_d = SHIFT;
        end else if (scan_q == '0) begin
          state_d = SPAWN;
        end else begin
          scan_d = scan_q - 1'b1;
        end
      end

      SHIFT: begin
        // Pull the row above down; the top row fills with zeros and the same
        // scan row is checked again since new content has moved into it.
        wr_en      = 1'b1;
        wr_row     = shift_q;
        row_a_addr = shift_q - 1'b1;
        if (shift_q == '0) begin
          wr_zero = 1'b1;
          state_d = SCAN;
        end else begin
          wr_data = row_a;
          shift_d = shift_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign active_x = x_q;
  assign active_y = y_q;
  assign lines    = lines_q;

endmodule
